// File: rtl/prog_writer.sv
// Nibble-stream program loader: assembles hi/lo nibble pairs into bytes and writes them
// into a byte memory from a start address; the fetch side reads {Q1,Q2} asynchronously.
module prog_writer #(
    parameter int ADDR_W = 12
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              En,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] load,
    input  logic [3:0]        nib_in,
    input  logic              nib_valid,
    output logic              nib_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        Q1,
    output logic [3:0]        Q2,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full
);

    // state    | meaning
    // IDLE     | no session; wr_addr/count held for inspection
    // GET_HI   | waiting for the high nibble
    // GET_LO   | waiting for the low nibble
    // WRITE    | committing {hi,lo} to mem[wr_addr]
    // FULL     | top address written; no further nibbles taken
    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_HI,
        S_GET_LO,
        S_WRITE,
        S_FULL
    } state_t;

    localparam int DEPTH = 1 << ADDR_W;

    state_t            state_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W:0]   count_q;
    logic [3:0]        hi_q;
    logic [3:0]        lo_q;
    logic              busy_q;
    logic              full_q;
    logic [7:0]        mem [DEPTH];

    logic              accept;
    logic              mem_we;
    logic [7:0]        rd_data;

    assign nib_ready = En && !stop && (state_q == S_GET_HI || state_q == S_GET_LO);
    assign accept    = nib_ready && nib_valid;
    assign mem_we    = !reset && En && (state_q == S_WRITE);

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wr_addr_q <= '0;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            full_q    <= 1'b0;
        end else if (En) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        wr_addr_q <= load;
                        count_q   <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_GET_HI;
                    end
                end
                S_GET_HI: begin
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (accept) begin
                        hi_q    <= nib_in;
                        state_q <= S_GET_LO;
                    end
                end
                S_GET_LO: begin
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (accept) begin
                        lo_q    <= nib_in;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    count_q <= count_q + 1'b1;
                    // no wrap at the top of memory: park in FULL on the last address
                    if (&wr_addr_q) begin
                        busy_q  <= 1'b0;
                        full_q  <= 1'b1;
                        state_q <= S_FULL;
                    end else begin
                        wr_addr_q <= wr_addr_q + 1'b1;
                        state_q   <= S_GET_HI;
                    end
                end
                S_FULL: begin
                    if (start) begin
                        wr_addr_q <= load;
                        count_q   <= '0;
                        busy_q    <= 1'b1;
                        full_q    <= 1'b0;
                        state_q   <= S_GET_HI;
                    end else if (stop) begin
                        full_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    full_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // memory is deliberately outside the reset domain so a loaded program survives reset
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[wr_addr_q] <= {hi_q, lo_q};
        end
    end

    assign rd_data = mem[rd_addr];
    assign Q1      = rd_data[7:4];
    assign Q2      = rd_data[3:0];
    assign wr_addr = wr_addr_q;
    assign count   = count_q;
    assign busy    = busy_q;
    assign full    = full_q;

endmodule

// File: tb/tb_prog_writer.sv
// Directed bench for prog_writer: a vector table for the main sessions plus
// hand-written sequences for enable stalls, mid-byte reset and read-during-write.
module tb_prog_writer;

    logic        Clk = 1'b0;
    logic        reset, En, start, stop, nib_valid;
    logic [11:0] load, rd_addr;
    logic [3:0]  nib_in;
    logic        nib_ready, busy, full;
    logic [3:0]  Q1, Q2;
    logic [11:0] wr_addr;
    logic [12:0] count;

    int checks = 0;
    int errors = 0;

    prog_writer #(.ADDR_W(12)) dut (
        .Clk(Clk), .reset(reset), .En(En), .start(start), .stop(stop),
        .load(load), .nib_in(nib_in), .nib_valid(nib_valid), .nib_ready(nib_ready),
        .rd_addr(rd_addr), .Q1(Q1), .Q2(Q2), .wr_addr(wr_addr), .count(count),
        .busy(busy), .full(full)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst, en, st, sp;
        logic [11:0] ld;
        logic [3:0]  nib;
        logic        nv;
        logic [11:0] ra;
        logic        crdy, rdy, bsy, fl;
        logic [11:0] wa;
        logic [12:0] cnt;
        logic        cq;
        logic [3:0]  q1, q2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, en, st, sp, input logic [11:0] ld,
                                input logic [3:0] nib, input logic nv, input logic [11:0] ra,
                                input logic crdy, rdy, bsy, fl, input logic [11:0] wa,
                                input logic [12:0] cnt, input logic cq, input logic [3:0] q1, q2);
        vec_t v;
        v.rst = rst; v.en = en; v.st = st; v.sp = sp; v.ld = ld; v.nib = nib; v.nv = nv;
        v.ra = ra; v.crdy = crdy; v.rdy = rdy; v.bsy = bsy; v.fl = fl; v.wa = wa;
        v.cnt = cnt; v.cq = cq; v.q1 = q1; v.q2 = q2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, en, st, sp, input logic [11:0] ld,
                         input logic [3:0] nib, input logic nv, input logic [11:0] ra);
        reset = rst; En = en; start = st; stop = sp; load = ld;
        nib_in = nib; nib_valid = nv; rd_addr = ra;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        //           rst en st sp ld      nib  nv ra       crdy rdy bsy fl wa       cnt  cq q1    q2
        vecs.push_back(mk(1, 0, 0, 0, 12'h000, 4'h0, 0, 12'h000, 0, 0, 0, 0, 12'h000, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 1, 1, 0, 12'h010, 4'h0, 0, 12'h000, 1, 0, 1, 0, 12'h010, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 1, 0, 0, 12'h000, 4'hA, 1, 12'h000, 1, 1, 1, 0, 12'h010, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 1, 1, 0, 12'h0FF, 4'h5, 1, 12'h000, 1, 1, 1, 0, 12'h010, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 1, 0, 0, 12'h000, 4'h0, 0, 12'h010, 1, 0, 1, 0, 12'h011, 1, 1, 4'hA, 4'h5));
        vecs.push_back(mk(0, 1, 0, 0, 12'h000, 4'h3, 1, 12'h010, 1, 1, 1, 0, 12'h011, 1, 1, 4'hA, 4'h5));
        vecs.push_back(mk(0, 1, 0, 0, 12'h000, 4'hC, 1, 12'h011, 1, 1, 1, 0, 12'h011, 1, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 1, 0, 1, 12'h000, 4'h0, 0, 12'h011, 1, 0, 1, 0, 12'h012, 2, 1, 4'h3, 4'hC));
        vecs.push_back(mk(0, 1, 0, 1, 12'h000, 4'h0, 0, 12'h000, 1, 0, 0, 0, 12'h012, 2, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 1, 0, 0, 12'h000, 4'h0, 0, 12'h000, 1, 0, 0, 0, 12'h012, 2, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 1, 1, 0, 12'h010, 4'h0, 0, 12'h000, 1, 0, 1, 0, 12'h010, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 1, 0, 0, 12'h000, 4'h7, 1, 12'h000, 1, 1, 1, 0, 12'h010, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 1, 0, 1, 12'h000, 4'h1, 1, 12'h010, 1, 0, 0, 0, 12'h010, 0, 1, 4'hA, 4'h5));
        vecs.push_back(mk(0, 1, 1, 0, 12'hFFE, 4'h0, 0, 12'h000, 1, 0, 1, 0, 12'hFFE, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 1, 0, 0, 12'h000, 4'h1, 1, 12'h000, 1, 1, 1, 0, 12'hFFE, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 1, 0, 0, 12'h000, 4'h2, 1, 12'h000, 1, 1, 1, 0, 12'hFFE, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 1, 0, 0, 12'h000, 4'h0, 0, 12'hFFE, 1, 0, 1, 0, 12'hFFF, 1, 1, 4'h1, 4'h2));
        vecs.push_back(mk(0, 1, 0, 0, 12'h000, 4'h3, 1, 12'h000, 1, 1, 1, 0, 12'hFFF, 1, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 1, 0, 0, 12'h000, 4'h4, 1, 12'h000, 1, 1, 1, 0, 12'hFFF, 1, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 1, 0, 0, 12'h000, 4'h5, 1, 12'hFFF, 1, 0, 0, 1, 12'hFFF, 2, 1, 4'h3, 4'h4));
        vecs.push_back(mk(0, 1, 0, 0, 12'h000, 4'h6, 1, 12'hFFF, 1, 0, 0, 1, 12'hFFF, 2, 1, 4'h3, 4'h4));
        vecs.push_back(mk(0, 1, 0, 1, 12'h000, 4'h0, 0, 12'h000, 1, 0, 0, 0, 12'hFFF, 2, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 1, 1, 0, 12'hFFF, 4'h0, 0, 12'h000, 1, 0, 1, 0, 12'hFFF, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 1, 0, 0, 12'h000, 4'h8, 1, 12'h000, 1, 1, 1, 0, 12'hFFF, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 1, 0, 0, 12'h000, 4'h9, 1, 12'h000, 1, 1, 1, 0, 12'hFFF, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 1, 0, 0, 12'h000, 4'h0, 0, 12'hFFF, 1, 0, 0, 1, 12'hFFF, 1, 1, 4'h8, 4'h9));
        vecs.push_back(mk(0, 1, 1, 0, 12'h030, 4'h0, 0, 12'h000, 1, 0, 1, 0, 12'h030, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(0, 1, 0, 1, 12'h000, 4'h0, 0, 12'h000, 1, 0, 0, 0, 12'h030, 0, 0, 4'h0, 4'h0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].st, vecs[i].sp, vecs[i].ld,
                  vecs[i].nib, vecs[i].nv, vecs[i].ra);
            #1;
            if (vecs[i].crdy) chk($sformatf("v%0d nib_ready", i), 32'(nib_ready), 32'(vecs[i].rdy));
            step();
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
            chk($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].fl));
            chk($sformatf("v%0d wr_addr", i), 32'(wr_addr), 32'(vecs[i].wa));
            chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
            if (vecs[i].cq) begin
                chk($sformatf("v%0d Q1", i), 32'(Q1), 32'(vecs[i].q1));
                chk($sformatf("v%0d Q2", i), 32'(Q2), 32'(vecs[i].q2));
            end
        end

        // enable stall in GET_LO: the nibble offered while En=0 must not be captured
        drive(0, 1, 1, 0, 12'h040, 4'h0, 0, 12'h000); step();
        drive(0, 1, 0, 0, 12'h000, 4'hB, 1, 12'h000); step();
        drive(0, 0, 0, 0, 12'h000, 4'hE, 1, 12'h000); #1;
        chk("en0 nib_ready", 32'(nib_ready), 32'd0);
        step();
        chk("en0 busy", 32'(busy), 32'd1);
        chk("en0 count", 32'(count), 32'd0);
        step();
        drive(0, 1, 0, 0, 12'h000, 4'hD, 1, 12'h000); #1;
        chk("en1 nib_ready", 32'(nib_ready), 32'd1);
        step();
        drive(0, 1, 0, 0, 12'h000, 4'h0, 0, 12'h040); step();
        chk("en resume Q1", 32'(Q1), 32'hB);
        chk("en resume Q2", 32'(Q2), 32'hD);
        chk("en resume count", 32'(count), 32'd1);
        chk("en resume wr_addr", 32'(wr_addr), 32'h041);

        // reset in GET_LO after mem[020]=99: memory survives, partial byte dropped
        drive(0, 1, 0, 1, 12'h000, 4'h0, 0, 12'h000); step();
        drive(0, 1, 1, 0, 12'h020, 4'h0, 0, 12'h000); step();
        drive(0, 1, 0, 0, 12'h000, 4'h9, 1, 12'h000); step();
        drive(0, 1, 0, 0, 12'h000, 4'h9, 1, 12'h000); step();
        drive(0, 1, 0, 0, 12'h000, 4'h0, 0, 12'h000); step();
        drive(0, 1, 0, 0, 12'h000, 4'h4, 1, 12'h000); step();
        drive(1, 1, 1, 1, 12'h0AA, 4'h6, 1, 12'h020); step();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst full", 32'(full), 32'd0);
        chk("rst wr_addr", 32'(wr_addr), 32'd0);
        chk("rst count", 32'(count), 32'd0);
        drive(0, 1, 0, 0, 12'h000, 4'h6, 1, 12'h020); #1;
        chk("rst nib_ready", 32'(nib_ready), 32'd0);
        chk("rst mem Q1", 32'(Q1), 32'h9);
        chk("rst mem Q2", 32'(Q2), 32'h9);
        step();
        chk("rst idle busy", 32'(busy), 32'd0);

        // read-during-write at 005: old data until the committing edge
        drive(0, 1, 1, 0, 12'h005, 4'h0, 0, 12'h000); step();
        drive(0, 1, 0, 0, 12'h000, 4'h1, 1, 12'h000); step();
        drive(0, 1, 0, 0, 12'h000, 4'h2, 1, 12'h000); step();
        drive(0, 1, 0, 0, 12'h000, 4'h0, 0, 12'h000); step();
        drive(0, 1, 0, 1, 12'h000, 4'h0, 0, 12'h000); step();
        drive(0, 1, 1, 0, 12'h005, 4'h0, 0, 12'h000); step();
        drive(0, 1, 0, 0, 12'h000, 4'h3, 1, 12'h000); step();
        drive(0, 1, 0, 0, 12'h000, 4'h4, 1, 12'h000); step();
        drive(0, 1, 0, 0, 12'h000, 4'h0, 0, 12'h005); #1;
        chk("rdw old Q1", 32'(Q1), 32'h1);
        chk("rdw old Q2", 32'(Q2), 32'h2);
        step();
        chk("rdw new Q1", 32'(Q1), 32'h3);
        chk("rdw new Q2", 32'(Q2), 32'h4);
        chk("rdw wr_addr", 32'(wr_addr), 32'h006);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_writer.md
PROG_WRITER -- requirements
Module: prog_writer

Interface
REQ-001 SHALL have parameter: ADDR_W, 12, address width; memory depth is 2^ADDR_W bytes.
REQ-002 SHALL have port: Clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: En  input  1  writer enable; when 0, the FSM holds and nib_ready=0.
REQ-005 SHALL have port: start  input  1  begin a load session at address load.
REQ-006 SHALL have port: stop  input  1  abort the session and return to IDLE.
REQ-007 SHALL have port: load  input  ADDR_W  session start address.
REQ-008 SHALL have port: nib_in  input  4  nibble data; high nibble first, then low nibble.
REQ-009 SHALL have port: nib_valid  input  1  nib_in valid.
REQ-010 SHALL have port: nib_ready  output  1  writer accepts a nibble this cycle.
REQ-011 SHALL have port: rd_addr  input  ADDR_W  fetch-side read address.
REQ-012 SHALL have port: Q1  output  4  mem[rd_addr][7:4], the instruction nibble.
REQ-013 SHALL have port: Q2  output  4  mem[rd_addr][3:0], the operand nibble.
REQ-014 SHALL have port: wr_addr  output  ADDR_W  current write pointer.
REQ-015 SHALL have port: count  output  ADDR_W+1  bytes written this session.
REQ-016 SHALL have port: busy  output  1  high in GET_HI, GET_LO and WRITE.
REQ-017 SHALL have port: full  output  1  high in FULL.

Function
REQ-018 SHALL implement the FSM states IDLE, GET_HI, GET_LO, WRITE and FULL; when En=0, every state holds and all registers keep their values.
REQ-019 IDLE: when start=1 and En=1, SHALL load wr_addr<=load, clear count to 0 and go to GET_HI; otherwise stay in IDLE.
REQ-020 SHALL drive nib_ready=1 only when in GET_HI or GET_LO, En=1 and stop=0; nib_ready SHALL be a combinational function of state, En and stop.
REQ-021 A nibble SHALL be accepted only on a rising edge where nib_valid=1 and nib_ready=1.
REQ-022 GET_HI: on accept, SHALL capture hi<=nib_in and go to GET_LO.
REQ-023 GET_LO: on accept, SHALL capture lo<=nib_in and go to WRITE.
REQ-024 WRITE: SHALL write mem[wr_addr]<={hi,lo} and increment count by 1.
REQ-025 WRITE: if wr_addr is all-ones, SHALL go to FULL with wr_addr unchanged (no wrap); otherwise SHALL increment wr_addr by 1 and go to GET_HI.
REQ-026 Throughput SHALL be at most one byte per 3 cycles; the write occurs on the edge that leaves WRITE.
REQ-027 Stop in GET_HI or GET_LO SHALL go to IDLE; any half-assembled byte is discarded and memory is untouched.
REQ-028 If stop and nib_valid are both high, stop SHALL win and the nibble SHALL not be consumed.
REQ-029 Stop SHALL be ignored in WRITE; the byte still commits.
REQ-030 Start SHALL be ignored in GET_HI, GET_LO and WRITE.
REQ-031 FULL: nib_ready SHALL be 0; start=1 with En=1 SHALL restart as in IDLE and clear full; stop=1 SHALL go to IDLE.
REQ-032 wr_addr and count SHALL hold their last values in IDLE for inspection.
REQ-033 The read port SHALL be asynchronous; a write and a read to the same address in the same cycle SHALL return old data until the edge.

Reset
REQ-034 When reset=1 at an edge, SHALL go to IDLE with wr_addr=0, count=0, hi=lo=0, full=0, busy=0 and nib_ready=0, regardless of state or other inputs.
REQ-035 Reset SHALL have priority over start, stop and En.
REQ-036 Memory contents SHALL NOT be cleared by reset.
REQ-037 Reset mid-byte SHALL discard the partial byte.

Verification
REQ-038 Reset, then load=12'h010, start, nibbles A,5,3,C -> mem[010]=8'hA5, mem[011]=8'h3C; rd_addr=010 gives Q1=A, Q2=5; count=2, wr_addr=012.
REQ-039 Load=12'hFFE, four bytes offered -> bytes 1–2 written at FFE and FFF, full=1, wr_addr=FFF, count=2; nib_ready stays 0 and later nibbles are not consumed.
REQ-040 After high nibble 7, assert stop together with nib_valid -> state IDLE, nibble not consumed, mem[wr_addr] unchanged.
REQ-041 En=0 while nib_valid=1 in GET_LO -> nib_ready=0, no capture; En=1 resumes and completes the byte.
REQ-042 Reset during GET_LO after mem[020]=8'h99 was written -> outputs at reset values, mem[020] still reads Q1=9, Q2=9.
REQ-043 Same-cycle write and read of address 005 -> old Q1/Q2 values before the edge, new values after it.
